// File: rtl/fp_add_seq.sv
// Control sequencer for a floating-point adder: walks align/add/normalize/round
// steps, tracks the result exponent and hands the result off with valid/ready.
module fp_add_seq #(
   parameter int ALIGN_MAX = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] exp1,
   input  logic [7:0] exp2,
   output logic       ld_ops,
   output logic       swap,
   output logic [1:0] n_concat,
   output logic       align_en,
   output logic       add_en,
   input  logic       carry,
   input  logic       msb,
   input  logic       sum_zero,
   output logic       norm_r_en,
   output logic       norm_l_en,
   output logic       round_en,
   output logic [7:0] exp_res,
   output logic       ovf,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_ROUND = 3'd4,
      S_POSTR = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [7:0] ALIGN_SAT = (ALIGN_MAX > 255) ? 8'hFF : 8'(ALIGN_MAX);

   state_t     r_state, w_state_nx;
   logic [7:0] r_exp_res, w_exp_nx;
   logic [7:0] r_count, w_count_nx;
   logic       r_swap, w_swap_nx;
   logic [1:0] r_n_concat, w_nc_nx;

   logic [7:0] w_e1, w_e2, w_diff, w_exp_inc;
   logic       w_swap_in;

   // Denormals behave as exponent 1 for alignment purposes.
   assign w_e1      = (exp1 == 8'h00) ? 8'h01 : exp1;
   assign w_e2      = (exp2 == 8'h00) ? 8'h01 : exp2;
   assign w_swap_in = (w_e2 > w_e1);
   assign w_diff    = w_swap_in ? (w_e2 - w_e1) : (w_e1 - w_e2);
   assign w_exp_inc = (r_exp_res == 8'hFF) ? 8'hFF : (r_exp_res + 8'h01);

   assign swap     = r_swap;
   assign n_concat = r_n_concat;
   assign exp_res  = r_exp_res;
   assign ovf      = (r_exp_res == 8'hFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_exp_res  <= 8'h00;
         r_count    <= 8'h00;
         r_swap     <= 1'b0;
         r_n_concat <= 2'b00;
      end else begin
         r_state    <= w_state_nx;
         r_exp_res  <= w_exp_nx;
         r_count    <= w_count_nx;
         r_swap     <= w_swap_nx;
         r_n_concat <= w_nc_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_exp_nx   = r_exp_res;
      w_count_nx = r_count;
      w_swap_nx  = r_swap;
      w_nc_nx    = r_n_concat;
      in_ready   = 1'b0;
      ld_ops     = 1'b0;
      align_en   = 1'b0;
      add_en     = 1'b0;
      norm_r_en  = 1'b0;
      norm_l_en  = 1'b0;
      round_en   = 1'b0;
      out_valid  = 1'b0;

      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ld_ops     = 1'b1;
               w_swap_nx  = w_swap_in;
               w_nc_nx    = {(exp1 == 8'h00), (exp2 == 8'h00)};
               w_exp_nx   = w_swap_in ? w_e2 : w_e1;
               w_count_nx = (w_diff > ALIGN_SAT) ? ALIGN_SAT : w_diff;
               w_state_nx = (w_count_nx != 8'h00) ? S_ALIGN : S_ADD;
            end
         end
         S_ALIGN: begin
            align_en   = 1'b1;
            w_count_nx = r_count - 8'h01;
            if (r_count <= 8'h01) w_state_nx = S_ADD;
         end
         S_ADD: begin
            add_en     = 1'b1;
            w_state_nx = S_NORM;
         end
         S_NORM: begin
            if (carry) begin
               norm_r_en  = 1'b1;
               w_exp_nx   = w_exp_inc;
               w_state_nx = S_ROUND;
            end else if (sum_zero) begin
               w_exp_nx   = 8'h00;
               w_state_nx = S_ROUND;
            end else if (!msb) begin
               // Left shifts stop at exponent 1; below that the result is denormal.
               if (r_exp_res > 8'h01) begin
                  norm_l_en = 1'b1;
                  w_exp_nx  = r_exp_res - 8'h01;
               end else begin
                  w_exp_nx   = 8'h00;
                  w_state_nx = S_ROUND;
               end
            end else begin
               w_state_nx = S_ROUND;
            end
         end
         S_ROUND: begin
            round_en   = 1'b1;
            w_state_nx = S_POSTR;
         end
         S_POSTR: begin
            if (carry) begin
               norm_r_en = 1'b1;
               w_exp_nx  = w_exp_inc;
            end else if ((r_exp_res == 8'h00) && msb) begin
               w_exp_nx = 8'h01;
            end
            w_state_nx = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (reset) begin
         in_ready  = 1'b0;
         ld_ops    = 1'b0;
         align_en  = 1'b0;
         add_en    = 1'b0;
         norm_r_en = 1'b0;
         norm_l_en = 1'b0;
         round_en  = 1'b0;
         out_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: emulates the datapath flags and checks against an
// arithmetic model of the exponent/latency rules.
module tb_fp_add_seq;

   localparam int AMAX = 27;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, ld_ops, swap, align_en, add_en;
   logic       carry, msb, sum_zero, norm_r_en, norm_l_en, round_en, ovf;
   logic       out_valid, out_ready;
   logic [7:0] exp1, exp2, exp_res;
   logic [1:0] n_concat;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         lat;
      int         n_align;
      int         n_left;
      int         n_right;
      logic [7:0] e;
      logic       ov;
      logic       sw;
      logic [1:0] nc;
      bit         ld;
      bit         multi;
      bit         unstable;
      bit         hold_bad;
      bit         rdy_in_done;
      bit         idle_after;
      bit         timeout;
   } obs_t;

   fp_add_seq #(.ALIGN_MAX(AMAX)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .exp1(exp1), .exp2(exp2), .ld_ops(ld_ops), .swap(swap), .n_concat(n_concat),
      .align_en(align_en), .add_en(add_en), .carry(carry), .msb(msb),
      .sum_zero(sum_zero), .norm_r_en(norm_r_en), .norm_l_en(norm_l_en),
      .round_en(round_en), .exp_res(exp_res), .ovf(ovf), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Reference: exponent bookkeeping of a float add, expressed arithmetically.
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input int nl,
                                 input bit ncy, input bit nz, input bit pcy, input bit pmsb,
                                 output int lat, output int cnt, output int left, output int right,
                                 output logic [7:0] e, output bit sw, output logic [1:0] nc);
      int e1, e2, d, ex;
      e1 = (a == 0) ? 1 : int'(a);
      e2 = (b == 0) ? 1 : int'(b);
      sw = (e2 > e1);
      nc = {a == 8'h00, b == 8'h00};
      d = (e1 > e2) ? e1 - e2 : e2 - e1;
      cnt = (d > AMAX) ? AMAX : d;
      ex = sw ? e2 : e1;
      left = 0;
      right = 0;
      if (ncy) begin
         ex = (ex >= 255) ? 255 : ex + 1;
         right++;
      end else if (nz) begin
         ex = 0;
      end else begin
         left = (nl < ex - 1) ? nl : ex - 1;
         ex = (nl > ex - 1) ? 0 : ex - nl;
      end
      if (pcy) begin
         ex = (ex >= 255) ? 255 : ex + 1;
         right++;
      end else if (ex == 0 && pmsb) begin
         ex = 1;
      end
      lat = 5 + cnt + left;
      e = ex[7:0];
   endfunction

   // Drives one operation through the DUT while acting as the datapath.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int nl,
                        input bit ncy, input bit nz, input bit pcy, input bit pmsb,
                        input int hold, output obs_t o);
      int  lefts, ph, nstb;
      bit  done;
      o = '{default: 0};
      lefts = 0;
      ph = 0;
      done = 0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         #1;
         if (in_ready) break;
      end
      if (!in_ready) begin
         o.timeout = 1;
         return;
      end
      exp1 = a;
      exp2 = b;
      in_valid = 1'b1;
      #1;
      o.ld = ld_ops;
      for (int t = 1; t <= 300 && !done; t++) begin
         @(negedge clk);
         in_valid = 1'b0;
         exp1 = 8'($urandom);
         exp2 = 8'($urandom);
         if (ph == 1) begin
            carry = ncy; sum_zero = nz; msb = (lefts < nl) ? 1'b0 : 1'b1;
         end else if (ph == 2) begin
            carry = pcy; sum_zero = 1'b0; msb = pmsb;
         end else begin
            carry = 1'($urandom); sum_zero = 1'($urandom); msb = 1'($urandom);
         end
         #1;
         nstb = int'(ld_ops) + int'(align_en) + int'(add_en) + int'(norm_r_en)
              + int'(norm_l_en) + int'(round_en);
         if (nstb > 1) o.multi = 1;
         if (t == 1) begin
            o.sw = swap;
            o.nc = n_concat;
         end else if (swap !== o.sw || n_concat !== o.nc) begin
            o.unstable = 1;
         end
         if (align_en) o.n_align++;
         if (norm_l_en) begin
            o.n_left++;
            lefts++;
         end
         if (norm_r_en) o.n_right++;
         if (add_en) ph = 1;
         if (round_en) ph = 2;
         if (out_valid) begin
            o.lat = t;
            o.e = exp_res;
            o.ov = ovf;
            if (in_ready) o.rdy_in_done = 1;
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               carry = 1'($urandom); msb = 1'($urandom); sum_zero = 1'($urandom);
               #1;
               if (out_valid !== 1'b1 || exp_res !== o.e || ovf !== o.ov || in_ready !== 1'b0
                   || swap !== o.sw || n_concat !== o.nc || align_en || add_en || norm_r_en
                   || norm_l_en || round_en)
                  o.hold_bad = 1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            o.idle_after = (in_ready === 1'b1) && (out_valid === 1'b0);
            done = 1;
         end
      end
      if (!done) o.timeout = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      carry = 1'b0; msb = 1'b0; sum_zero = 1'b0; exp1 = 8'h00; exp2 = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_cycle in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || swap !== 1'b0 || n_concat !== 2'b00 || exp_res !== 8'h00
          || ovf !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_vals rdy=%b swap=%b nc=%b exp=%h ovf=%b ov=%b want 1 0 00 00 0 0",
                  in_ready, swap, n_concat, exp_res, ovf, out_valid);
      end
      n_vec++;
      if ({ld_ops, align_en, add_en, norm_r_en, norm_l_en, round_en} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_strobes got %b want 000000",
                  {ld_ops, align_en, add_en, norm_r_en, norm_l_en, round_en});
      end
   endtask

   task automatic test_equal_exp();
      obs_t o;
      do_op(8'h80, 8'h80, 0, 0, 0, 0, 1, 0, o);
      n_vec++;
      if (o.timeout || o.ld !== 1'b1 || o.sw !== 1'b0 || o.n_align != 0) begin
         n_err++;
         $display("FAIL equal_ctrl to=%0d ld=%b swap=%b align=%0d want 0 1 0 0",
                  o.timeout, o.ld, o.sw, o.n_align);
      end
      n_vec++;
      if (o.lat != 5 || o.e !== 8'h80) begin
         n_err++;
         $display("FAIL equal_res lat=%0d exp=%h want 5 80", o.lat, o.e);
      end
   endtask

   task automatic test_swap_align();
      obs_t o;
      do_op(8'h7E, 8'h82, 0, 0, 0, 0, 1, 0, o);
      n_vec++;
      if (o.sw !== 1'b1 || o.n_align != 4 || o.e !== 8'h82 || o.lat != 9) begin
         n_err++;
         $display("FAIL swap_align swap=%b align=%0d exp=%h lat=%0d want 1 4 82 9",
                  o.sw, o.n_align, o.e, o.lat);
      end
   endtask

   task automatic test_align_sat();
      obs_t o;
      do_op(8'h90, 8'h68, 0, 0, 0, 0, 1, 0, o);
      n_vec++;
      if (o.sw !== 1'b0 || o.n_align != 27 || o.e !== 8'h90 || o.lat != 32) begin
         n_err++;
         $display("FAIL align_sat swap=%b align=%0d exp=%h lat=%0d want 0 27 90 32",
                  o.sw, o.n_align, o.e, o.lat);
      end
   endtask

   task automatic test_overflow();
      obs_t o;
      do_op(8'hFE, 8'hFE, 0, 1, 0, 0, 1, 2, o);
      n_vec++;
      if (o.n_right != 1 || o.e !== 8'hFF || o.ov !== 1'b1 || o.hold_bad) begin
         n_err++;
         $display("FAIL overflow nr=%0d exp=%h ovf=%b hold_bad=%0d want 1 ff 1 0",
                  o.n_right, o.e, o.ov, o.hold_bad);
      end
   endtask

   task automatic test_zero_operands();
      obs_t o;
      do_op(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, o);
      n_vec++;
      if (o.nc !== 2'b11 || o.e !== 8'h00 || o.ov !== 1'b0 || o.n_left != 0) begin
         n_err++;
         $display("FAIL zero_ops nc=%b exp=%h ovf=%b nl=%0d want 11 00 0 0",
                  o.nc, o.e, o.ov, o.n_left);
      end
   endtask

   task automatic test_norm_left_hold();
      obs_t o;
      do_op(8'h40, 8'h40, 3, 0, 0, 0, 1, 4, o);
      n_vec++;
      if (o.n_left != 3 || o.e !== 8'h3D || o.lat != 8) begin
         n_err++;
         $display("FAIL norm_left nl=%0d exp=%h lat=%0d want 3 3d 8", o.n_left, o.e, o.lat);
      end
      n_vec++;
      if (o.hold_bad || o.rdy_in_done || !o.idle_after) begin
         n_err++;
         $display("FAIL hold bad=%0d rdy_done=%0d idle_after=%0d want 0 0 1",
                  o.hold_bad, o.rdy_in_done, o.idle_after);
      end
   endtask

   task automatic test_reset_mid_align();
      bit seen;
      @(negedge clk);
      #1;
      exp1 = 8'h90; exp2 = 8'h68; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (align_en !== 1'b1) begin
         n_err++;
         $display("FAIL mid_align_start align_en=%b want 1", align_en);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      n_vec++;
      if ({align_en, in_ready, out_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL mid_align_rst align=%b rdy=%b ov=%b want 0 0 0", align_en, in_ready, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || align_en !== 1'b0 || out_valid !== 1'b0 || exp_res !== 8'h00
          || swap !== 1'b0) begin
         n_err++;
         $display("FAIL mid_align_after rdy=%b align=%b ov=%b exp=%h swap=%b want 1 0 0 00 0",
                  in_ready, align_en, out_valid, exp_res, swap);
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (out_valid || align_en || !in_ready) seen = 1;
      end
      n_vec++;
      if (seen) begin
         n_err++;
         $display("FAIL mid_align_discard activity=1 want 0");
      end
   endtask

   task automatic test_random();
      obs_t       o;
      logic [7:0] a, b, e;
      logic [1:0] nc;
      int         nl, hold, lat, cnt, left, right;
      bit         ncy, nz, pcy, pmsb, sw;
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         case ($urandom_range(0, 4))
            0: b = a ^ 8'($urandom_range(0, 7));
            1: b = 8'h00;
            2: begin a = 8'($urandom_range(0, 3)); b = 8'($urandom_range(0, 5)); end
            3: begin a = 8'($urandom_range(250, 254)); b = a; end
            default: b = 8'($urandom);
         endcase
         nl   = $urandom_range(0, 4);
         ncy  = ($urandom_range(0, 3) == 0);
         nz   = ($urandom_range(0, 7) == 0);
         pcy  = ($urandom_range(0, 3) == 0);
         pmsb = 1'($urandom);
         hold = $urandom_range(0, 2);
         model(a, b, nl, ncy, nz, pcy, pmsb, lat, cnt, left, right, e, sw, nc);
         do_op(a, b, nl, ncy, nz, pcy, pmsb, hold, o);
         n_vec++;
         if (o.timeout || o.lat != lat || o.n_align != cnt || o.n_left != left
             || o.n_right != right) begin
            n_err++;
            $display("FAIL rnd%0d_timing a=%h b=%h to=%0d lat=%0d/%0d align=%0d/%0d nl=%0d/%0d nr=%0d/%0d (got/want)",
                     i, a, b, o.timeout, o.lat, lat, o.n_align, cnt, o.n_left, left, o.n_right, right);
         end
         n_vec++;
         if (o.e !== e || o.ov !== (e == 8'hFF) || o.sw !== sw || o.nc !== nc) begin
            n_err++;
            $display("FAIL rnd%0d_result a=%h b=%h exp=%h/%h ovf=%b/%b swap=%b/%b nc=%b/%b (got/want)",
                     i, a, b, o.e, e, o.ov, (e == 8'hFF), o.sw, sw, o.nc, nc);
         end
         n_vec++;
         if (!o.ld || o.multi || o.unstable || o.hold_bad || o.rdy_in_done || !o.idle_after) begin
            n_err++;
            $display("FAIL rnd%0d_proto ld=%0d multi=%0d unstable=%0d hold_bad=%0d rdy_done=%0d idle=%0d want 1 0 0 0 0 1",
                     i, o.ld, o.multi, o.unstable, o.hold_bad, o.rdy_in_done, o.idle_after);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_equal_exp();
      test_swap_align();
      test_align_sat();
      test_overflow();
      test_zero_operands();
      test_norm_left_hold();
      test_reset_mid_align();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
